mlp_layer_sched: RTL and testbench

Sequencer for the shared 8-lane MAC datapath of the MLP inference core. On `start` it walks the hidden layer (4 neuron groups of 8, 62 inputs each) and then the output layer (2 groups of 8, 30 inputs each). For every group it drives bank select, input-element index, accumulator clear/enable, bias add and result write-back, so a single MAC array serves all six groups. It sits between the top-level control and the MAC array and the weight/bias bank multiplexers.

---
 rtl/mlp_layer_sched.sv | 171 +++++++++++++++++
 tb/tb_mlp_layer_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sched.sv
// rtl/mlp_layer_sched.sv - group/element sequencer for the shared 8-lane MAC datapath of the MLP core
module mlp_layer_sched #(
    parameter int N_HID_GRP = 4,
    parameter int N_OUT_GRP = 2,
    parameter int IN_LEN    = 62,
    parameter int HID_LEN   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    output logic       busy,
    output logic       done,
    output logic       layer,
    output logic [1:0] bank_sel,
    output logic [5:0] elem_idx,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       bias_en,
    output logic       wr_en,
    output logic [2:0] wr_grp
);

    // Counter widths are fixed at 6/2 bits, so lengths and group counts must fit them.
    if (IN_LEN < 1 || IN_LEN > 64 || HID_LEN < 1 || HID_LEN > 64 ||
        N_HID_GRP < 1 || N_HID_GRP > 4 || N_OUT_GRP < 1 || N_OUT_GRP > 4) begin : g_bad_params
        $error("mlp_layer_sched: parameter out of range");
    end

    localparam logic [5:0] HID_LAST_IDX = 6'(IN_LEN - 1);
    localparam logic [5:0] OUT_LAST_IDX = 6'(HID_LEN - 1);
    localparam logic [1:0] HID_LAST_GRP = 2'(N_HID_GRP - 1);
    localparam logic [1:0] OUT_LAST_GRP = 2'(N_OUT_GRP - 1);

    typedef enum logic [2:0] {IDLE, CLR, ACC, BIAS, WB, FIN} state_t;

    state_t     state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       layer_q, layer_d;
    logic [1:0] bank_q, bank_d;
    logic [5:0] idx_q, idx_d;
    logic       clr_q, clr_d;
    logic       en_q, en_d;
    logic       bias_q, bias_d;
    logic       wr_q, wr_d;

    logic [5:0] last_idx;
    logic [1:0] last_grp;

    assign last_idx = layer_q ? OUT_LAST_IDX : HID_LAST_IDX;
    assign last_grp = layer_q ? OUT_LAST_GRP : HID_LAST_GRP;

    // Next-state and next-output logic; strobes are computed for the state being entered.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        layer_d = layer_q;
        bank_d  = bank_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        clr_d   = 1'b0;
        en_d    = 1'b0;
        bias_d  = 1'b0;
        wr_d    = 1'b0;
        if (hold && state_q != IDLE) begin
            // Frozen: everything keeps its value, strobes stay low until hold drops.
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = CLR;
                        busy_d  = 1'b1;
                        layer_d = 1'b0;
                        bank_d  = 2'd0;
                        idx_d   = 6'd0;
                        clr_d   = 1'b1;
                    end
                end
                CLR: begin
                    state_d = ACC;
                    idx_d   = 6'd0;
                    en_d    = 1'b1;
                end
                ACC: begin
                    if (idx_q == last_idx) begin
                        state_d = BIAS;
                        bias_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        en_d  = 1'b1;
                    end
                end
                BIAS: begin
                    state_d = WB;
                    wr_d    = 1'b1;
                end
                WB: begin
                    if (bank_q < last_grp) begin
                        state_d = CLR;
                        bank_d  = bank_q + 2'd1;
                        idx_d   = 6'd0;
                        clr_d   = 1'b1;
                    end else if (!layer_q) begin
                        state_d = CLR;
                        layer_d = 1'b1;
                        bank_d  = 2'd0;
                        idx_d   = 6'd0;
                        clr_d   = 1'b1;
                    end else begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        layer_d = 1'b0;
                        bank_d  = 2'd0;
                        idx_d   = 6'd0;
                        done_d  = 1'b1;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    layer_d = 1'b0;
                    bank_d  = 2'd0;
                    idx_d   = 6'd0;
                end
            endcase
        end
    end

    // State and registered outputs; reset aborts any run without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            layer_q <= 1'b0;
            bank_q  <= 2'd0;
            idx_q   <= 6'd0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            bias_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            layer_q <= layer_d;
            bank_q  <= bank_d;
            idx_q   <= idx_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            bias_q  <= bias_d;
            wr_q    <= wr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign layer    = layer_q;
    assign bank_sel = bank_q;
    assign elem_idx = idx_q;
    assign mac_clr  = clr_q;
    assign mac_en   = en_q;
    assign bias_en  = bias_q;
    assign wr_en    = wr_q;
    assign wr_grp   = {1'b0, bank_q};

endmodule

// File: tb/tb_mlp_layer_sched.sv
// tb/tb_mlp_layer_sched.sv - self-checking bench for mlp_layer_sched (default and small parameter sets)
module tb_mlp_layer_sched;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic hold;

    logic       busy0, done0, layer0, mac_clr0, mac_en0, bias_en0, wr_en0;
    logic [1:0] bank_sel0;
    logic [5:0] elem_idx0;
    logic [2:0] wr_grp0;
    logic       busy1, done1, layer1, mac_clr1, mac_en1, bias_en1, wr_en1;
    logic [1:0] bank_sel1;
    logic [5:0] elem_idx1;
    logic [2:0] wr_grp1;

    mlp_layer_sched u_dut0 (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .busy(busy0), .done(done0), .layer(layer0), .bank_sel(bank_sel0),
        .elem_idx(elem_idx0), .mac_clr(mac_clr0), .mac_en(mac_en0),
        .bias_en(bias_en0), .wr_en(wr_en0), .wr_grp(wr_grp0)
    );

    mlp_layer_sched #(.N_HID_GRP(4), .N_OUT_GRP(2), .IN_LEN(4), .HID_LEN(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .busy(busy1), .done(done1), .layer(layer1), .bank_sel(bank_sel1),
        .elem_idx(elem_idx1), .mac_clr(mac_clr1), .mac_en(mac_en1),
        .bias_en(bias_en1), .wr_en(wr_en1), .wr_grp(wr_grp1)
    );

    always #5 clk = ~clk;

    // Output bundle layout: busy done layer bank[2] idx[6] clr en bias wr grp[3]
    logic [31:0] outs0, outs1;
    assign outs0 = {14'd0, busy0, done0, layer0, bank_sel0, elem_idx0, mac_clr0, mac_en0, bias_en0, wr_en0, wr_grp0};
    assign outs1 = {14'd0, busy1, done1, layer1, bank_sel1, elem_idx1, mac_clr1, mac_en1, bias_en1, wr_en1, wr_grp1};

    localparam logic [31:0] STROBES = 32'h0001_0078;

    typedef logic [31:0] vq_t[$];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    vq_t sched0, sched1;
    int  pos[2];
    bit  held[2];

    int done_e0[$], done_e1[$];
    int wr_log0[$];
    int cnt_clr0, cnt_en0, cnt_bias0, cnt_wr0, cnt_en1, cnt_clr1, cnt_wr1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input bit b, input bit d, input int l, input int g, input int i,
                                       input bit c, input bit e, input bit bi, input bit w);
        logic [1:0] g2;
        g2 = 2'(g);
        return {14'd0, b, d, 1'(l), g2, 6'(i), c, e, bi, w, 1'b0, g2};
    endfunction

    // Flat list of what each cycle of one inference should show, in order.
    function automatic vq_t build(input int in_len, input int hid_len, input int nh, input int no);
        vq_t q;
        for (int l = 0; l < 2; l++) begin
            int ng = (l == 0) ? nh : no;
            int k  = (l == 0) ? in_len : hid_len;
            for (int g = 0; g < ng; g++) begin
                q.push_back(pk(1, 0, l, g, 0, 1, 0, 0, 0));
                for (int i = 0; i < k; i++) q.push_back(pk(1, 0, l, g, i, 0, 1, 0, 0));
                q.push_back(pk(1, 0, l, g, k - 1, 0, 0, 1, 0));
                q.push_back(pk(1, 0, l, g, k - 1, 0, 0, 0, 1));
            end
        end
        q.push_back(pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        return q;
    endfunction

    function automatic logic [31:0] expv(input int d);
        logic [31:0] v;
        if (pos[d] < 0) return 32'd0;
        v = (d == 0) ? sched0[pos[d]] : sched1[pos[d]];
        return held[d] ? (v & ~STROBES) : v;
    endfunction

    task automatic model_adv(input int d, input logic s, input logic h, input logic r);
        int len;
        len = (d == 0) ? sched0.size() : sched1.size();
        if (r) begin
            pos[d] = -1; held[d] = 0;
        end else if (pos[d] < 0) begin
            if (s) begin pos[d] = 0; held[d] = 0; end
        end else if (h) begin
            held[d] = 1;
        end else begin
            held[d] = 0;
            pos[d]++;
            if (pos[d] >= len) pos[d] = -1;
        end
    endtask

    task automatic clear_logs();
        done_e0.delete(); done_e1.delete(); wr_log0.delete();
        cnt_clr0 = 0; cnt_en0 = 0; cnt_bias0 = 0; cnt_wr0 = 0;
        cnt_en1 = 0; cnt_clr1 = 0; cnt_wr1 = 0;
    endtask

    task automatic tick(input logic s, input logic h);
        start = s;
        hold  = h;
        @(posedge clk);
        edge_n++;
        model_adv(0, s, h, rst);
        model_adv(1, s, h, rst);
        #1;
        chk("outs_dflt", outs0, expv(0));
        chk("outs_small", outs1, expv(1));
        if (done0) done_e0.push_back(edge_n);
        if (done1) done_e1.push_back(edge_n);
        if (wr_en0) wr_log0.push_back({28'd0, layer0, wr_grp0});
        cnt_clr0  += int'(mac_clr0);
        cnt_en0   += int'(mac_en0);
        cnt_bias0 += int'(bias_en0);
        cnt_wr0   += int'(wr_en0);
        cnt_en1   += int'(mac_en1);
        cnt_clr1  += int'(mac_clr1);
        cnt_wr1   += int'(wr_en1);
    endtask

    function automatic int rel(input int q[$], input int idx, input int s);
        if (q.size() <= idx) return -1;
        return q[idx] - s + 1;
    endfunction

    int  s_edge;
    bit  found;
    int  exp_wr[6] = '{0, 1, 2, 3, 8, 9};

    initial begin
        sched0 = build(62, 30, 4, 2);
        sched1 = build(4, 2, 4, 2);
        pos[0] = -1; pos[1] = -1; held[0] = 0; held[1] = 0;
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        #2;
        chk("reset_outs_dflt", outs0, 32'd0);
        chk("reset_outs_small", outs1, 32'd0);
        tick(0, 0);
        tick(0, 1);
        rst = 1'b0;
        tick(0, 1);
        tick(0, 0);

        // Single clean inference on both parameter sets
        clear_logs();
        s_edge = edge_n + 1;
        tick(1, 0);
        repeat (335) tick(0, 0);
        chk("done_count", done_e0.size(), 1);
        chk("done_cycle", rel(done_e0, 0, s_edge), 327);
        chk("clr_count", cnt_clr0, 6);
        chk("mac_en_count", cnt_en0, 308);
        chk("bias_count", cnt_bias0, 6);
        chk("wr_count", cnt_wr0, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("wr_seq%0d", i), (wr_log0.size() > i) ? wr_log0[i] : -1, exp_wr[i]);
        chk("small_done_count", done_e1.size(), 1);
        chk("small_done_cycle", rel(done_e1, 0, s_edge), 39);
        chk("small_mac_en_count", cnt_en1, 20);
        chk("small_clr_count", cnt_clr1, 6);
        chk("small_wr_count", cnt_wr1, 6);

        // Hold for 5 cycles at hidden group 2, element 40
        clear_logs();
        s_edge = edge_n + 1;
        tick(1, 0);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick(0, 0);
            if (layer0 == 1'b0 && bank_sel0 == 2'd2 && elem_idx0 == 6'd40 && mac_en0) found = 1;
        end
        chk("hold_point_found", 32'(found), 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1);
            chk("hold_idx", 32'(elem_idx0), 40);
            chk("hold_no_mac", 32'(mac_en0), 0);
        end
        tick(0, 0);
        chk("resume_idx", 32'(elem_idx0), 41);
        chk("resume_mac", 32'(mac_en0), 1);
        repeat (340) tick(0, 0);
        chk("hold_done_count", done_e0.size(), 1);
        chk("hold_done_cycle", rel(done_e0, 0, s_edge), 332);
        chk("hold_mac_en_count", cnt_en0, 308);

        // Starts while busy/finishing are ignored; start after done restarts
        clear_logs();
        s_edge = edge_n + 1;
        for (int r = 0; r < 700; r++) tick(r == 0 || r == 50 || r == 327 || r == 328, 0);
        chk("restart_done_count", done_e0.size(), 2);
        chk("restart_done1", rel(done_e0, 0, s_edge), 327);
        chk("restart_done2", rel(done_e0, 1, s_edge), 655);

        // Asynchronous reset in hidden group 3
        clear_logs();
        s_edge = edge_n + 1;
        tick(1, 0);
        repeat (198) tick(0, 0);
        chk("pre_reset_busy", 32'(busy0), 1);
        #3;
        rst = 1'b1;
        pos[0] = -1; pos[1] = -1; held[0] = 0; held[1] = 0;
        #1;
        chk("async_rst_dflt", outs0, 32'd0);
        chk("async_rst_small", outs1, 32'd0);
        tick(0, 0);
        tick(1, 0);
        rst = 1'b0;
        repeat (5) tick(0, 0);
        chk("rst_no_done", done_e0.size(), 0);
        clear_logs();
        s_edge = edge_n + 1;
        tick(1, 0);
        repeat (335) tick(0, 0);
        chk("post_rst_done_cycle", rel(done_e0, 0, s_edge), 327);
        chk("post_rst_mac_en", cnt_en0, 308);
        chk("post_rst_wr", cnt_wr0, 6);

        // Random start/hold traffic against the schedule model
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
